ab_pattern_gen: RTL and testbench
=================================

Name: ab_pattern_gen

Overview:
- Transmitter side of the A/B sequence detector: drives `a_out`/`b_out` so that a downstream A-then-B detector sees a programmed burst of complete A→B sequences.
- Each sequence is spaced by a programmable idle gap.
- Used as the stimulus source in front of the two-input detector in the fsm_warmup design, and as a self-checking traffic source in benches.
- start/busy/done handshake to the controlling logic.

Parameters:
- CNT_W, 8, width of `burst_len` and `sent_cnt`.
- GAP_W, 4, width of `gap_len`; max inter-sequence idle = 2^GAP_W-1 cycles.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request a burst; sampled only in IDLE.
- burst_len  input  CNT_W  number of A→B sequences; latched on accepted start.
- gap_len  input  GAP_W  idle cycles after each HOLD; latched on accepted start.
- abort  input  1  terminate the active burst.
- q_in  input  1  detector match pulse, used only with the echo check.
- a_out  output  1  A drive to the detector, registered.
- b_out  output  1  B drive to the detector, registered.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a burst completes normally.
- sent_cnt  output  CNT_W  sequences sent in the current or last burst.
- echo_err  output  1  sticky echo mismatch flag.

Behaviour:
- Reset is synchronous, active-low: `reset`=0 at a posedge forces IDLE with `a_out`=`b_out`=`busy`=`done`=`echo_err`=0 and `sent_cnt`=0.
  - Reset mid-burst behaves the same; no `done` pulse.
- All outputs are registered and decoded from the next state, so they are valid for the whole cycle the FSM sits in a state.
- States: IDLE, SEND_A, SEND_B, HOLD, GAP, DONE.
- IDLE:
  - `start`=1 and `burst_len`≠0 → SEND_A. Latch `burst_len` and `gap_len`, clear `sent_cnt`, clear `echo_err`.
  - `start`=1 and `burst_len`=0 → DONE. No A/B activity; `sent_cnt` clears to 0.
- SEND_A: `a_out`=1, `b_out`=0, exactly one cycle → SEND_B.
- SEND_B: `a_out`=0, `b_out`=1, exactly one cycle → HOLD. `sent_cnt` increments on leaving SEND_B.
- HOLD: both outputs 0 for one cycle; matches the detector's one-cycle recovery after a match.
  - Then: `sent_cnt`==latched `burst_len` → DONE.
  - Otherwise latched gap≠0 → GAP; gap=0 → SEND_A.
- GAP: both outputs 0; down-counter loaded with the latched gap; stays exactly gap cycles, then → SEND_A.
- DONE: `done`=1, `busy`=1 for one cycle → IDLE.
- Sequence period is 3 + gap cycles. Burst length in cycles, from the first SEND_A to DONE inclusive, is N·3 + (N-1)·gap + 1.
- `start` while busy is ignored; input changes after latch have no effect.
- `abort`=1 in any non-IDLE state (including DONE):
  - next state IDLE, `a_out`/`b_out` 0 next cycle;
  - no `done` pulse;
  - `sent_cnt` holds its value.
  - `abort` in IDLE has no effect; `abort` and `start` together in IDLE: start wins.
- `sent_cnt` never wraps: at most `burst_len` ≤ 2^CNT_W-1.

Optional Feature:
- AB_ECHO_CHECK_EN defined:
  - While busy, `q_in` is sampled each cycle.
  - HOLD with `q_in`=0, or any other busy state with `q_in`=1, sets `echo_err`.
  - `echo_err` is sticky until the next accepted `start` or reset; it is unaffected by `abort`.
  - Assumes `q_in` is driven by a detector that registers its match pulse, so the pulse is high exactly during HOLD.
- Undefined: `q_in` is ignored and `echo_err` is tied to 0. Ports exist in both builds.

Test Plan:
- Reset low 2 cycles, then high; `burst_len`=3, `gap_len`=0, `start` pulse → `a_out` high in cycles 1, 4, 7 after start and `b_out` in cycles 2, 5, 8; `done` in cycle 10; `sent_cnt`=3; `busy` high cycles 1–10.
- `burst_len`=2, `gap_len`=2 → `a_out` in cycles 1 and 6 after start; `done` in cycle 9; `sent_cnt`=2.
- `burst_len`=0, `start` → `done` in cycle 1, `a_out`/`b_out` never high, `sent_cnt`=0.
- `burst_len`=5, `gap_len`=1, `abort` in the cycle after the 2nd SEND_B → IDLE next cycle, no `done`, `sent_cnt`=2. A new `start` the following cycle is accepted. Repeat with `reset`=0 instead of `abort` → all outputs 0, `sent_cnt`=0.
- AB_ECHO_CHECK_EN, outputs wired to the detector's A/B inputs and its Q to `q_in`, `burst_len`=4, `gap_len`=3 → `echo_err` stays 0 and 4 Q pulses are seen.
- Same build with `q_in` tied 0 → `echo_err` rises in the first HOLD and stays 1 through `done`; the next `start` clears it.

Source files
------------

// File: rtl/ab_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// ab_pattern_gen_if
//   Bundles the control handshake and the A/B drive signals of ab_pattern_gen.
//
//   master : controlling logic / bench. Drives start, burst_len, gap_len, abort
//            and the detector echo q_in. Observes a_out, b_out, busy, done,
//            sent_cnt and echo_err.
//   slave  : ab_pattern_gen itself (mirror of master).
//
//   Parameters
//     CNT_W : width of burst_len / sent_cnt
//     GAP_W : width of gap_len
// -----------------------------------------------------------------------------
interface ab_pattern_gen_if #(
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
);
   logic             start;
   logic [CNT_W-1:0] burst_len;
   logic [GAP_W-1:0] gap_len;
   logic             abort;
   logic             q_in;
   logic             a_out;
   logic             b_out;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] sent_cnt;
   logic             echo_err;

   modport master (
      output start, burst_len, gap_len, abort, q_in,
      input  a_out, b_out, busy, done, sent_cnt, echo_err
   );

   modport slave (
      input  start, burst_len, gap_len, abort, q_in,
      output a_out, b_out, busy, done, sent_cnt, echo_err
   );
endinterface

// File: rtl/ab_pattern_gen.sv
// -----------------------------------------------------------------------------
// ab_pattern_gen
//   Transmitter side of the A/B sequence detector. On an accepted start it
//   emits burst_len complete A->B sequences (A for one cycle, B for one cycle,
//   one idle HOLD cycle), separated by gap_len idle cycles, then pulses done.
//
//   Ports
//     clk      : clock, everything on posedge
//     reset    : synchronous, active-low reset
//     bus      : ab_pattern_gen_if.slave
//                start/burst_len/gap_len/abort in, q_in detector echo in,
//                a_out/b_out drive, busy/done handshake, sent_cnt progress,
//                echo_err sticky echo mismatch flag
//
//   Build option
//     AB_ECHO_CHECK_EN : when defined, q_in is compared against the expected
//                        detector response (high exactly during HOLD) and
//                        mismatches set echo_err. When undefined q_in is
//                        ignored and echo_err is constant 0.
//
//   All outputs are registered and decoded from the next state, so each one is
//   valid for the full cycle the FSM spends in the corresponding state.
// -----------------------------------------------------------------------------
module ab_pattern_gen #(
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   ab_pattern_gen_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SEND_A = 3'd1,
      S_SEND_B = 3'd2,
      S_HOLD   = 3'd3,
      S_GAP    = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [CNT_W-1:0] burst_lat;
   logic [GAP_W-1:0] gap_lat;
   logic [GAP_W-1:0] gap_cnt;
   logic [CNT_W-1:0] sent_cnt;

   logic             a_reg;
   logic             b_reg;
   logic             busy_reg;
   logic             done_reg;

   logic             a_nxt;
   logic             b_nxt;
   logic             busy_nxt;
   logic             done_nxt;

   logic             start_acc;
   logic             gap_load;
   logic             seq_sent;

   // start is only honoured from IDLE; abort never competes with it there.
   assign start_acc = (state == S_IDLE) && bus.start;

   // Entering GAP from HOLD loads the down-counter; the last GAP cycle is the
   // one where the counter reads zero, giving exactly gap_lat GAP cycles.
   assign gap_load  = (state == S_HOLD) && (state_nxt == S_GAP);

   // A sequence counts once SEND_B completes normally (not cut by abort).
   assign seq_sent  = (state == S_SEND_B) && (state_nxt == S_HOLD);

   // ---------------------------------------------------------------------------
   // State register (and registered outputs)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         a_reg    <= 1'b0;
         b_reg    <= 1'b0;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         state    <= state_nxt;
         a_reg    <= a_nxt;
         b_reg    <= b_nxt;
         busy_reg <= busy_nxt;
         done_reg <= done_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               // An empty burst still completes with a done pulse.
               state_nxt = (bus.burst_len != '0) ? S_SEND_A : S_DONE;
            end
         end
         S_SEND_A: state_nxt = S_SEND_B;
         S_SEND_B: state_nxt = S_HOLD;
         S_HOLD: begin
            // sent_cnt already includes the sequence that just finished.
            if (sent_cnt == burst_lat) begin
               state_nxt = S_DONE;
            end else if (gap_lat != '0) begin
               state_nxt = S_GAP;
            end else begin
               state_nxt = S_SEND_A;
            end
         end
         S_GAP: begin
            if (gap_cnt == '0) begin
               state_nxt = S_SEND_A;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      // abort overrides every busy-state transition, DONE included.
      if ((state != S_IDLE) && bus.abort) begin
         state_nxt = S_IDLE;
      end
   end

   // ---------------------------------------------------------------------------
   // Output decode from the next state
   // ---------------------------------------------------------------------------
   always_comb begin
      a_nxt    = (state_nxt == S_SEND_A);
      b_nxt    = (state_nxt == S_SEND_B);
      busy_nxt = (state_nxt != S_IDLE);
      done_nxt = (state_nxt == S_DONE);
   end

   // ---------------------------------------------------------------------------
   // Burst configuration latch; pure data, loaded only on accepted start
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (start_acc) begin
         burst_lat <= bus.burst_len;
         gap_lat   <= bus.gap_len;
      end
   end

   // ---------------------------------------------------------------------------
   // Inter-sequence gap down-counter
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (gap_load) begin
         gap_cnt <= gap_lat - GAP_W'(1);
      end else if ((state == S_GAP) && (gap_cnt != '0)) begin
         gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Sent-sequence counter; holds across abort, cleared on start and reset.
   // burst_lat bounds it, so it cannot wrap.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         sent_cnt <= '0;
      end else if (start_acc) begin
         sent_cnt <= '0;
      end else if (seq_sent) begin
         sent_cnt <= sent_cnt + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Detector echo check
   // ---------------------------------------------------------------------------
`ifdef AB_ECHO_CHECK_EN
   logic echo_reg;
   logic echo_bad;

   // A registering detector raises Q exactly while we sit in HOLD; any other
   // busy cycle must see Q low.
   assign echo_bad = (state != S_IDLE) && ((state == S_HOLD) != bus.q_in);

   always_ff @(posedge clk) begin
      if (!reset) begin
         echo_reg <= 1'b0;
      end else if (start_acc) begin
         echo_reg <= 1'b0;
      end else if (echo_bad) begin
         echo_reg <= 1'b1;
      end
   end

   assign bus.echo_err = echo_reg;
`else
   assign bus.echo_err = 1'b0;
`endif

   assign bus.a_out    = a_reg;
   assign bus.b_out    = b_reg;
   assign bus.busy     = busy_reg;
   assign bus.done     = done_reg;
   assign bus.sent_cnt = sent_cnt;

endmodule

// File: tb/tb_ab_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_ab_pattern_gen
//   Scoreboard bench for ab_pattern_gen. For every burst the expected per-cycle
//   output trace (a_out, b_out, busy, done, echo_err, sent_cnt) is generated from
//   the burst parameters and queued when start is driven; each following cycle
//   one entry is popped and compared against the DUT, sampled 1ns after posedge.
// -----------------------------------------------------------------------------
module tb_ab_pattern_gen;
   localparam int CNT_W = 8;
   localparam int GAP_W = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   ab_pattern_gen_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

   ab_pattern_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

`ifdef AB_ECHO_CHECK_EN
   // Registering A-then-B detector model: Q is high the cycle after B that
   // follows A, i.e. during the generator's HOLD.
   logic a_seen = 1'b0;
   logic det_q  = 1'b0;
   logic q_tie  = 1'b0;
   int   q_cnt  = 0;
   always_ff @(posedge clk) begin
      a_seen <= bus.a_out;
      det_q  <= a_seen & bus.b_out;
      if (det_q) q_cnt <= q_cnt + 1;
   end
   assign bus.q_in = q_tie ? 1'b0 : det_q;
`else
   logic q_rand = 1'b0;
   assign bus.q_in = q_rand;
`endif

   typedef struct packed {
      logic             a;
      logic             b;
      logic             busy;
      logic             done;
      logic             echo;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   exp_t tr_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input int obs, input int exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic exp_t mk(input bit a, input bit b, input bit busy,
                               input bit done, input bit echo, input int cnt);
      exp_t e;
      e.a = a; e.b = b; e.busy = busy; e.done = done; e.echo = echo;
      e.cnt = CNT_W'(cnt);
      return e;
   endfunction

   // Full uninterrupted trace, cycle 1 after start first, ending with IDLE.
   task automatic build_trace(input int n, input int gap, input bit tie);
      bit err = 1'b0;
      tr_q.delete();
      for (int i = 0; i < n; i++) begin
         tr_q.push_back(mk(1, 0, 1, 0, err, i));
         tr_q.push_back(mk(0, 1, 1, 0, err, i));
         tr_q.push_back(mk(0, 0, 1, 0, err, i + 1));
         if (tie) err = 1'b1;   // HOLD without Q shows up the next cycle
         if (i < n - 1)
            for (int g = 0; g < gap; g++) tr_q.push_back(mk(0, 0, 1, 0, err, i + 1));
      end
      tr_q.push_back(mk(0, 0, 1, 1, err, n));
      tr_q.push_back(mk(0, 0, 0, 0, err, n));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
`ifndef AB_ECHO_CHECK_EN
      q_rand = 1'($urandom_range(0, 1));
`endif
   endtask

   task automatic compare_entry(input string name, input int k);
      exp_t e;
      e = sb_q.pop_front();
      check_val($sformatf("%s c%0d a_out",    name, k), int'(bus.a_out),    int'(e.a));
      check_val($sformatf("%s c%0d b_out",    name, k), int'(bus.b_out),    int'(e.b));
      check_val($sformatf("%s c%0d busy",     name, k), int'(bus.busy),     int'(e.busy));
      check_val($sformatf("%s c%0d done",     name, k), int'(bus.done),     int'(e.done));
      check_val($sformatf("%s c%0d echo_err", name, k), int'(bus.echo_err), int'(e.echo));
      check_val($sformatf("%s c%0d sent_cnt", name, k), int'(bus.sent_cnt), int'(e.cnt));
   endtask

   // abort_at / rst_at : cycle after start in which abort / reset=0 is driven
   // (0 = none). scramble: wiggle start/burst_len/gap_len while busy.
   // abort_start: abort high together with start in IDLE.
   task automatic run_burst(input string name, input int n, input int gap,
                            input int abort_at, input int rst_at,
                            input bit scramble, input bit abort_start, input bit tie);
      exp_t nx;
      int   len;
      int   k;
      build_trace(n, gap, tie);
      if (abort_at > 0) begin
         nx = tr_q[abort_at];
         while (tr_q.size() > abort_at) void'(tr_q.pop_back());
         tr_q.push_back(mk(0, 0, 0, 0, nx.echo, int'(tr_q[abort_at-1].cnt)));
      end else if (rst_at > 0) begin
         while (tr_q.size() > rst_at) void'(tr_q.pop_back());
         tr_q.push_back(mk(0, 0, 0, 0, 0, 0));
         tr_q.push_back(mk(0, 0, 0, 0, 0, 0));
      end
      len = tr_q.size();
      foreach (tr_q[i]) sb_q.push_back(tr_q[i]);

      bus.burst_len = CNT_W'(n);
      bus.gap_len   = GAP_W'(gap);
      bus.start     = 1'b1;
      bus.abort     = abort_start;
      k = 0;
      while (sb_q.size() > 0 && k < 2000) begin
         tick();
         k++;
         compare_entry(name, k);
         bus.start = 1'b0;
         bus.abort = 1'b0;
         reset     = 1'b1;
         if (scramble && k <= len - 2) begin
            bus.start     = 1'($urandom_range(0, 1));
            bus.burst_len = CNT_W'($urandom);
            bus.gap_len   = GAP_W'($urandom);
         end
         if (k == abort_at) bus.abort = 1'b1;
         if (k == rst_at)   reset     = 1'b0;
      end
      if (sb_q.size() > 0) begin
         check_val({name, " drain"}, sb_q.size(), 0);
         sb_q.delete();
      end
   endtask

   // Idle cycles with abort held high: nothing may move.
   task automatic idle_abort(input string name, input int cnt, input bit echo);
      for (int i = 1; i <= 2; i++) begin
         sb_q.push_back(mk(0, 0, 0, 0, echo, cnt));
         bus.abort = 1'b1;
         tick();
         compare_entry(name, i);
      end
      bus.abort = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b0;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.burst_len = '0;
      bus.gap_len   = '0;

      // Reset held for two cycles
      sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
      sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
      tick(); compare_entry("reset", 1);
      tick(); compare_entry("reset", 2);
      reset = 1'b1;
      sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
      tick(); compare_entry("post_reset", 1);

      run_burst("n3_g0",     3, 0, 0, 0, 0, 0, 0);
      idle_abort("idle_abort", 3, 0);
      run_burst("n2_g2",     2, 2, 0, 0, 0, 0, 0);
      run_burst("n0",        0, 0, 0, 0, 0, 0, 0);
      run_burst("abort",     5, 1, 7, 0, 0, 0, 0);
      run_burst("after_abt", 1, 0, 0, 0, 0, 0, 0);
      run_burst("rst_mid",   5, 1, 0, 7, 0, 0, 0);
      run_burst("after_rst", 2, 1, 0, 0, 0, 0, 0);
      run_burst("scramble",  4, 3, 0, 0, 1, 0, 0);
      run_burst("abt_start", 2, 0, 0, 0, 0, 1, 0);
      run_burst("abt_done",  2, 1, 8, 0, 0, 0, 0);
      run_burst("gap_max",   3, 15, 0, 0, 0, 0, 0);
      run_burst("cnt_max",   255, 0, 0, 0, 0, 0, 0);

`ifdef AB_ECHO_CHECK_EN
      q_cnt = 0;
      run_burst("echo_ok",   4, 3, 0, 0, 0, 0, 0);
      check_val("echo_ok q_pulses", q_cnt, 4);
      q_tie = 1'b1;
      run_burst("echo_tie",  2, 1, 0, 0, 0, 0, 1);
      idle_abort("echo_hold", 2, 1);
      q_tie = 1'b0;
      run_burst("echo_clr",  1, 0, 0, 0, 0, 0, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
